// File: rtl/open_regfile_pkg.sv
// -----------------------------------------------------------------------------
// open_regfile_pkg
// Shared types and helpers for the open_regfile register file:
//   clr_state_t - clear-engine FSM state (idle / sweeping)
//   byte_merge  - byte-lane merge of a new word into an old word under byte
//                 enables; used by both the storage write path and the read
//                 forwarding path so the two can never disagree.
// -----------------------------------------------------------------------------
package open_regfile_pkg;

  // Widest entry the merge helper handles. Callers pad narrower words up to
  // this width and slice the result back down.
  localparam int MAX_DWIDTH = 512;
  localparam int MAX_NBYTES = MAX_DWIDTH / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Byte k of the result comes from new_word when be[k] is set, else old_word.
  function automatic logic [MAX_DWIDTH-1:0] byte_merge(
    input logic [MAX_DWIDTH-1:0] old_word,
    input logic [MAX_DWIDTH-1:0] new_word,
    input logic [MAX_NBYTES-1:0] be
  );
    logic [MAX_DWIDTH-1:0] merged;
    merged = old_word;
    for (int k = 0; k < MAX_NBYTES; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/open_regfile_if.sv
// -----------------------------------------------------------------------------
// open_regfile_if
// Bus bundle between the datapath (master) and the register file (slave).
//   i_wr/i_waddr/i_wdata/i_wbe  write request, address, data, byte enables
//   i_raddr_a/i_raddr_b         read addresses for the two read ports
//   o_rdata_a/o_rdata_b         combinational read data
//   i_clr                       request a full clear sweep
//   o_busy                      clear sweep in progress
//   o_drop                      one-cycle pulse: a write was discarded
//   o_datalane                  every entry side by side, entry i at
//                               [DWIDTH*i +: DWIDTH]
// -----------------------------------------------------------------------------
interface open_regfile_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
);
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  logic                    i_wr;
  logic [AWIDTH-1:0]       i_waddr;
  logic [DWIDTH-1:0]       i_wdata;
  logic [NBYTES-1:0]       i_wbe;
  logic [AWIDTH-1:0]       i_raddr_a;
  logic [AWIDTH-1:0]       i_raddr_b;
  logic [DWIDTH-1:0]       o_rdata_a;
  logic [DWIDTH-1:0]       o_rdata_b;
  logic                    i_clr;
  logic                    o_busy;
  logic                    o_drop;
  logic [DWIDTH*DEPTH-1:0] o_datalane;

  modport master (
    output i_wr, i_waddr, i_wdata, i_wbe, i_raddr_a, i_raddr_b, i_clr,
    input  o_rdata_a, o_rdata_b, o_busy, o_drop, o_datalane
  );

  modport slave (
    input  i_wr, i_waddr, i_wdata, i_wbe, i_raddr_a, i_raddr_b, i_clr,
    output o_rdata_a, o_rdata_b, o_busy, o_drop, o_datalane
  );

endinterface

// File: rtl/open_regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
// Clear engine: on a clear request in IDLE it walks a pointer over every
// entry, one per clock, then returns to IDLE. Requests during a sweep are
// ignored.
//   clk, rst   clock, asynchronous active-low reset
//   clr        clear request (sampled in IDLE only)
//   busy       registered: sweep in progress
//   clr_en     strobe: zero entry clr_addr on this edge
//   clr_addr   entry being zeroed
// -----------------------------------------------------------------------------
module regfile_clr_seq
  import open_regfile_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_en,
  output logic [AWIDTH-1:0] clr_addr
);

  clr_state_t        state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == {AWIDTH{1'b1}}) begin
          // Last entry is zeroed on this edge; sweep done.
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AWIDTH'(1);
        end
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_en   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/open_regfile.sv
// -----------------------------------------------------------------------------
// open_regfile
// Multi-port register file with byte-enabled writes, two combinational read
// ports with write-through forwarding, an optional hardwired-zero entry 0,
// a sequenced clear engine and every entry exposed on o_datalane.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset; zeroes all entries, stops any sweep
//   bus   open_regfile_if slave modport (write, read, clear, status, lanes)
// -----------------------------------------------------------------------------
module open_regfile
  import open_regfile_pkg::*;
#(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  open_regfile_if.slave  bus
);

  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  if ((DWIDTH % 8) != 0 || DWIDTH >= MAX_DWIDTH) begin : g_bad_width
    $error("open_regfile: DWIDTH must be a multiple of 8 and below MAX_DWIDTH");
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              clr_en;
  logic [AWIDTH-1:0] clr_addr;
  logic              busy;

  regfile_clr_seq #(
    .AWIDTH (AWIDTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.i_clr),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // ---------------------------------------------------------------------------
  // Write qualification. A write to the hardwired-zero entry is neither
  // accepted nor reported as a drop. While sweeping, writes are discarded.
  // ---------------------------------------------------------------------------
  logic wr_to_zero;
  logic wr_accept;
  logic wr_drop;

  assign wr_to_zero = (ZERO_REG != 0) && (bus.i_waddr == '0);
  assign wr_accept  = bus.i_wr && !clr_en && !wr_to_zero;
  assign wr_drop    = bus.i_wr &&  clr_en && !wr_to_zero;

  // Merged word for the addressed entry; feeds both storage and forwarding.
  logic [MAX_DWIDTH-1:0] old_pad, new_pad, merged_pad;
  logic [MAX_NBYTES-1:0] be_pad;
  logic [DWIDTH-1:0]     wr_merged;
  logic                  unused_merge_hi;

  always_comb begin
    old_pad              = '0;
    new_pad              = '0;
    be_pad               = '0;
    old_pad[DWIDTH-1:0]  = mem[bus.i_waddr];
    new_pad[DWIDTH-1:0]  = bus.i_wdata;
    be_pad[NBYTES-1:0]   = bus.i_wbe;
    merged_pad           = byte_merge(old_pad, new_pad, be_pad);
    wr_merged            = merged_pad[DWIDTH-1:0];
  end

  // Padding bits are always zero and carry no information.
  assign unused_merge_hi = ^merged_pad[MAX_DWIDTH-1:DWIDTH];

  // ---------------------------------------------------------------------------
  // Storage. The sweep and a write can never target the same edge because
  // writes are only accepted in IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: the array sits in the reset branch on purpose: reset must leave
  // every entry at zero, so this storage is flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      mem[bus.i_waddr] <= wr_merged;
    end
  end

  logic drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= 1'b0;
    else      drop_q <= wr_drop;
  end

  // ---------------------------------------------------------------------------
  // Read ports: zero entry first, then forwarding, then stored value.
  // ---------------------------------------------------------------------------
  logic rd_zero_a, rd_zero_b;

  assign rd_zero_a = (ZERO_REG != 0) && (bus.i_raddr_a == '0);
  assign rd_zero_b = (ZERO_REG != 0) && (bus.i_raddr_b == '0);

  assign bus.o_rdata_a = rd_zero_a                                  ? '0        :
                         (wr_accept && bus.i_waddr == bus.i_raddr_a) ? wr_merged :
                                                                      mem[bus.i_raddr_a];
  assign bus.o_rdata_b = rd_zero_b                                  ? '0        :
                         (wr_accept && bus.i_waddr == bus.i_raddr_b) ? wr_merged :
                                                                      mem[bus.i_raddr_b];

  assign bus.o_busy = busy;
  assign bus.o_drop = drop_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign bus.o_datalane[DWIDTH*g +: DWIDTH] = mem[g];
  end

endmodule

// File: tb/tb_open_regfile.sv
// -----------------------------------------------------------------------------
// tb_open_regfile
// Self-checking bench for open_regfile at default parameters. Read ports are
// checked against a vector table; stored contents are checked through a
// scoreboard of expected entry values pushed when each write is driven and
// popped after the edge. Clear, drop, reset and simultaneous cases are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_open_regfile;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  open_regfile_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  open_regfile #(
    .AWIDTH   (AW),
    .DWIDTH   (DW),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    int          addr;
    logic [31:0] value;
  } sb_item_t;

  sb_item_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] entry(input int i);
    return bus.o_datalane[32*i +: 32];
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  task automatic idle_inputs();
    bus.i_wr      = 1'b0;
    bus.i_waddr   = '0;
    bus.i_wdata   = '0;
    bus.i_wbe     = '0;
    bus.i_raddr_a = '0;
    bus.i_raddr_b = '0;
    bus.i_clr     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sb_q.delete();
  endtask

  // Drive a write request; 'accepted' says whether the design should take it.
  task automatic drive_write(input int addr, input logic [31:0] data,
                             input logic [3:0] be, input bit accepted);
    logic [31:0] m;
    logic [4:0]  a5;
    sb_item_t    it;
    a5          = addr[4:0];
    bus.i_wr    = 1'b1;
    bus.i_waddr = a5;
    bus.i_wdata = data;
    bus.i_wbe   = be;
    m = be_mask(be);
    if (accepted && addr != 0) model[addr] = (model[addr] & ~m) | (data & m);
    it.addr  = addr;
    it.value = model[addr];
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input string name);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
    end else begin
      it = sb_q.pop_front();
      check(name, entry(it.addr), it.value);
    end
  endtask

  initial begin
    int busy_cnt;
    int guard;

    vecs[0] = '{1'b1, 5'd3,  32'hAABBCCDD, 4'hF,    5'd3,  5'd0,  32'hAABBCCDD, 32'h0};
    vecs[1] = '{1'b1, 5'd3,  32'h11223344, 4'b0101, 5'd3,  5'd3,  32'hAA22CC44, 32'hAA22CC44};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF,    5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 5'd7,  32'hDEADBEEF, 4'h0,    5'd7,  5'd3,  32'h0,        32'hAA22CC44};
    vecs[4] = '{1'b1, 5'd7,  32'hCAFEF00D, 4'b1000, 5'd7,  5'd6,  32'hCA000000, 32'h0};
    vecs[5] = '{1'b0, 5'd7,  32'h12345678, 4'hF,    5'd7,  5'd3,  32'hCA000000, 32'hAA22CC44};
    vecs[6] = '{1'b1, 5'd31, 32'h12345678, 4'b0011, 5'd30, 5'd31, 32'h0,        32'h00005678};
    vecs[7] = '{1'b1, 5'd5,  32'h00000055, 4'hF,    5'd5,  5'd7,  32'h00000055, 32'hCA000000};

    idle_inputs();
    model_reset();

    // ---------------- reset ----------------
    #12;
    check("por_busy", 32'(bus.o_busy), 32'h0);
    check("por_drop", 32'(bus.o_drop), 32'h0);
    check("por_datalane_zero", 32'(|bus.o_datalane), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int a = 1; a <= 3; a++) begin
      drive_write(a, 32'hA0A0_0000 | a, 4'hF, 1'b1);
      tick();
      sb_check("pre_reset_write");
    end
    idle_inputs();
    bus.i_raddr_a = 5'd2;
    #2;
    rst = 1'b0;
    #1;
    check("reset_datalane_zero", 32'(|bus.o_datalane), 32'h0);
    check("reset_busy", 32'(bus.o_busy), 32'h0);
    check("reset_drop", 32'(bus.o_drop), 32'h0);
    check("reset_rdata_a", bus.o_rdata_a, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---------------- table: byte writes, forwarding, zero entry ----------------
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        drive_write(int'(vecs[i].waddr), vecs[i].wdata, vecs[i].wbe, 1'b1);
      end else begin
        bus.i_wr    = 1'b0;
        bus.i_waddr = vecs[i].waddr;
        bus.i_wdata = vecs[i].wdata;
        bus.i_wbe   = vecs[i].wbe;
      end
      bus.i_raddr_a = vecs[i].ra;
      bus.i_raddr_b = vecs[i].rb;
      #1;
      check($sformatf("vec%0d_rdata_a", i), bus.o_rdata_a, vecs[i].exp_a);
      check($sformatf("vec%0d_rdata_b", i), bus.o_rdata_b, vecs[i].exp_b);
      tick();
      if (vecs[i].wr) sb_check($sformatf("vec%0d_entry", i));
      check($sformatf("vec%0d_drop", i), 32'(bus.o_drop), 32'h0);
    end
    idle_inputs();

    // ---------------- clear sequence ----------------
    for (int a = 1; a < DEPTH; a++) begin
      drive_write(a, 32'(a), 4'hF, 1'b1);
      tick();
      sb_check("fill_entry");
    end
    idle_inputs();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    check("clr_busy_rise", 32'(bus.o_busy), 32'h1);
    busy_cnt = bus.o_busy ? 1 : 0;
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      if (bus.o_busy) busy_cnt++;
      check($sformatf("clr_zeroed_%0d", c - 1), entry(c - 1), 32'h0);
      if (c < DEPTH) check($sformatf("clr_pending_%0d", c), entry(c), 32'(c));
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clr_busy_fall", 32'(bus.o_busy), 32'h0);
    model_reset();

    // A new request is taken on the first cycle busy is low.
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    check("clr_reaccept", 32'(bus.o_busy), 32'h1);
    guard = 0;
    while (bus.o_busy && guard < 40) begin
      tick();
      guard++;
    end
    check("clr_reaccept_done", 32'(bus.o_busy), 32'h0);

    // ---------------- drop and reset mid-clear ----------------
    drive_write(5, 32'h5A5A5A5A, 4'hF, 1'b1);
    tick();
    sb_check("pre_drop_e5");
    drive_write(20, 32'h00000020, 4'hF, 1'b1);
    tick();
    sb_check("pre_drop_e20");
    idle_inputs();
    bus.i_clr = 1'b1;
    tick();                                   // E0: sweep starts
    bus.i_clr = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    drive_write(5, 32'hFFFFFFFF, 4'hF, 1'b0);
    bus.i_raddr_a = 5'd5;
    #1;
    check("no_fwd_in_clear", bus.o_rdata_a, 32'h5A5A5A5A);
    tick();                                   // E3
    check("drop_pulse_1", 32'(bus.o_drop), 32'h1);
    sb_check("drop_entry5_hold_1");
    drive_write(5, 32'hFFFFFFFF, 4'hF, 1'b0);
    tick();                                   // E4
    check("drop_pulse_2", 32'(bus.o_drop), 32'h1);
    sb_check("drop_entry5_hold_2");
    idle_inputs();
    tick();                                   // E5
    check("drop_clear_after", 32'(bus.o_drop), 32'h0);
    check("entry5_before_turn", entry(5), 32'h5A5A5A5A);
    tick();                                   // E6
    check("entry5_swept", entry(5), 32'h0);
    for (int c = 7; c <= 10; c++) tick();     // E7..E10: pointer now 10
    check("entry20_pending", entry(20), 32'h00000020);
    check("busy_mid_clear", 32'(bus.o_busy), 32'h1);
    rst = 1'b0;
    #1;
    check("midclr_reset_busy", 32'(bus.o_busy), 32'h0);
    check("midclr_reset_zero", 32'(|bus.o_datalane), 32'h0);
    check("midclr_reset_drop", 32'(bus.o_drop), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("midclr_stays_idle", 32'(bus.o_busy), 32'h0);

    // ---------------- simultaneous write and clear ----------------
    drive_write(31, 32'h12345678, 4'hF, 1'b1);
    bus.i_clr = 1'b1;
    tick();                                   // E0
    idle_inputs();
    sb_check("simul_write_commit");
    check("simul_busy", 32'(bus.o_busy), 32'h1);
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      if (c == 31) check("simul_hold_31", entry(31), 32'h12345678);
      if (c == 32) begin
        check("simul_cleared", entry(31), 32'h0);
        check("simul_busy_fall", 32'(bus.o_busy), 32'h0);
      end
    end
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
